// File: rtl/outbuff_cntl.sv
// Output-buffer control: skid FIFO between encode engine and SRAM FIFO, with stripe row counting.
// Optional stall counter enabled by defining OUTBUFF_CNTL_STALL_CNT_EN.
module outbuff_cntl #(
  parameter int M_MAX         = 128,
  parameter int M_MIN         = 2,
  parameter int W             = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int OUT_W         = W * PACKET_LENGTH,
  parameter int SKID_DEPTH    = 4,
  parameter int M_W           = $clog2(M_MAX + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             eng_rstn,
  input  logic             cntrl_outbuff_wr_en,
  input  logic [M_W-1:0]   MReg,
  input  logic [OUT_W-1:0] eng_res_data,
  input  logic             eng_res_val,
  output logic             eng_res_rdy,
  output logic             cntl_outbuf_fifo_wr_rq,
  output logic [OUT_W-1:0] cntl_outbuf_fifo_wr_data,
  input  logic             outbuf_fifo_cntl_full,
  output logic             stripe_done,
  output logic [15:0]      stripe_cnt,
  output logic             cfg_err,
  output logic             partial_err
`ifdef OUTBUFF_CNTL_STALL_CNT_EN
  , output logic [31:0]    stall_cycles
`endif
);

  localparam int AW = $clog2(SKID_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [M_W-1:0] M_MIN_W = M_W'(M_MIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                            state_q, state_d;
  logic [PW-1:0]                     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SKID_DEPTH-1:0][OUT_W-1:0]  mem_q, mem_d;
  logic [M_W-1:0]                    m_lat_q, m_lat_d, row_q, row_d;
  logic [15:0]                       scnt_q, scnt_d;
  logic                              done_q, done_d, cfg_q, cfg_d, part_q, part_d;
  logic                              rdy_q, rdy_d;
  logic                              empty, full_d, push, pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = eng_res_val & rdy_q;
  assign pop   = ~empty & ~outbuf_fifo_cntl_full & (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    m_lat_d  = m_lat_q;
    row_d    = row_q;
    scnt_d   = scnt_q;
    done_d   = 1'b0;
    cfg_d    = cfg_q;
    part_d   = part_q;

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = eng_res_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      if (row_q == m_lat_q - 1'b1) begin
        row_d  = '0;
        scnt_d = scnt_q + 1'b1;
        done_d = 1'b1;
      end else begin
        row_d = row_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cntrl_outbuff_wr_en) begin
          if (MReg >= M_MIN_W) begin
            state_d = S_RUN;
            m_lat_d = MReg;
          end else begin
            cfg_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!cntrl_outbuff_wr_en) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (empty) begin
          state_d = S_IDLE;
          if (row_q != '0) begin
            part_d = 1'b1;
            row_d  = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!eng_rstn) begin
      state_d  = S_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      mem_d    = '0;
      m_lat_d  = '0;
      row_d    = '0;
      scnt_d   = '0;
      done_d   = 1'b0;
      cfg_d    = 1'b0;
      part_d   = 1'b0;
    end

    // Ready is precomputed from next-cycle pointers so it is exact for the cycle it is used.
    full_d = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    rdy_d  = (state_d == S_RUN) & ~full_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
      m_lat_q  <= '0;
      row_q    <= '0;
      scnt_q   <= '0;
      done_q   <= 1'b0;
      cfg_q    <= 1'b0;
      part_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
      m_lat_q  <= m_lat_d;
      row_q    <= row_d;
      scnt_q   <= scnt_d;
      done_q   <= done_d;
      cfg_q    <= cfg_d;
      part_q   <= part_d;
      rdy_q    <= rdy_d;
    end
  end

  assign eng_res_rdy              = rdy_q;
  assign cntl_outbuf_fifo_wr_rq   = pop;
  assign cntl_outbuf_fifo_wr_data = mem_q[rd_ptr_q[AW-1:0]];
  assign stripe_done              = done_q;
  assign stripe_cnt               = scnt_q;
  assign cfg_err                  = cfg_q;
  assign partial_err              = part_q;

`ifdef OUTBUFF_CNTL_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (!eng_rstn) begin
      stall_q <= '0;
    end else if (~empty & outbuf_fifo_cntl_full & (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_outbuff_cntl.sv
// Randomized bench for outbuff_cntl against a queue-based behavioural model.
module tb_outbuff_cntl;
  localparam int M_W   = 8;
  localparam int OUT_W = 8;
  localparam int D     = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             eng_rstn = 1'b1;
  logic             wr_en = 1'b0;
  logic [M_W-1:0]   mreg = 8'd4;
  logic [OUT_W-1:0] data = '0;
  logic             val = 1'b0;
  logic             full = 1'b0;
  logic             rdy, wr_rq, done, cfg, part;
  logic [OUT_W-1:0] wdata;
  logic [15:0]      scnt_o;
`ifdef OUTBUFF_CNTL_STALL_CNT_EN
  logic [31:0]      stall_o;
`endif

  outbuff_cntl #(.M_MAX(128), .M_MIN(2), .W(4), .PACKET_LENGTH(2), .SKID_DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .eng_rstn(eng_rstn), .cntrl_outbuff_wr_en(wr_en), .MReg(mreg),
    .eng_res_data(data), .eng_res_val(val), .eng_res_rdy(rdy),
    .cntl_outbuf_fifo_wr_rq(wr_rq), .cntl_outbuf_fifo_wr_data(wdata),
    .outbuf_fifo_cntl_full(full), .stripe_done(done), .stripe_cnt(scnt_o),
    .cfg_err(cfg), .partial_err(part)
`ifdef OUTBUFF_CNTL_STALL_CNT_EN
    , .stall_cycles(stall_o)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // Model: mode 0 idle, 1 running, 2 draining.
  int               mode, m_lat, row, scnt, done_seen;
  bit               done_e, cfg_e, part_e;
  longint           stall_e;
  logic [OUT_W-1:0] q[$];
  logic [OUT_W-1:0] sent[$];
  logic [OUT_W-1:0] got[$];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic model_clear();
    mode = 0; m_lat = 0; row = 0; scnt = 0;
    done_e = 0; cfg_e = 0; part_e = 0; stall_e = 0;
    q.delete();
  endtask

  // Called at a negedge with inputs already driven; checks, advances model, ends at next negedge.
  task automatic step();
    bit rdy_e, wr_e, done_n;
    int sz;
    #1;
    sz    = q.size();
    rdy_e = (mode == 1) && (sz < D);
    wr_e  = (sz > 0) && !full && (mode != 0);
    chk("eng_res_rdy", rdy, rdy_e);
    chk("wr_rq", wr_rq, wr_e);
    if (wr_e) chk("wr_data", wdata, q[0]);
    chk("stripe_done", done, done_e);
    chk("stripe_cnt", scnt_o, scnt);
    chk("cfg_err", cfg, cfg_e);
    chk("partial_err", part, part_e);
`ifdef OUTBUFF_CNTL_STALL_CNT_EN
    chk("stall_cycles", stall_o, stall_e);
`endif
    if (done) done_seen++;
    if (wr_rq) got.push_back(wdata);

    if (!eng_rstn) begin
      model_clear();
    end else begin
      done_n = 0;
      if (sz > 0 && full && stall_e != 64'hFFFF_FFFF) stall_e++;
      if (wr_e) begin
        void'(q.pop_front());
        if (row == m_lat - 1) begin row = 0; scnt++; done_n = 1; end
        else row++;
      end
      if (val && rdy_e) q.push_back(data);
      case (mode)
        0: if (wr_en) begin
             if (mreg >= 2) begin mode = 1; m_lat = mreg; end
             else cfg_e = 1;
           end
        1: if (!wr_en) mode = 2;
        default: if (sz == 0) begin
             mode = 0;
             if (row != 0) begin part_e = 1; row = 0; end
           end
      endcase
      done_e = done_n;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit f, input bit rnd);
    bit acc;
    val = v; full = f;
    acc = v && (mode == 1) && (q.size() < D);
    if (acc) sent.push_back(data);
    step();
    if (acc) data = rnd ? OUT_W'($urandom) : data + 1'b1;
  endtask

  task automatic send_n(input int n, input bit rnd);
    int start, cyc;
    start = sent.size();
    cyc = 0;
    while (sent.size() - start < n && cyc < n * 20 + 50) begin
      drive(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, rnd ? ($urandom_range(0, 3) == 0) : 1'b0, rnd);
      cyc++;
    end
    val = 1'b0;
    chk("send_count", sent.size() - start, n);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    wr_en = 1'b0; val = 1'b0; full = 1'b0;
    while (mode != 0 && cyc < 200) begin step(); cyc++; end
    chk("drain_timeout", mode, 0);
  endtask

  task automatic ers();
    eng_rstn = 1'b0; wr_en = 1'b0; val = 1'b0; full = 1'b0;
    step();
    eng_rstn = 1'b1;
    sent.delete(); got.delete(); done_seen = 0;
  endtask

  task automatic start_run(input logic [M_W-1:0] m);
    mreg = m; wr_en = 1'b1;
    step();
  endtask

  initial begin
    int accepts, mism;
    model_clear();
    done_seen = 0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", rdy, 0);
    chk("rst_wr_rq", wr_rq, 0);
    chk("rst_scnt", scnt_o, 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_part", part, 0);
    chk("rst_done", done, 0);
    rstn = 1'b1;
    step();

    // Two full stripes of 4
    ers(); start_run(8'd4);
    send_n(8, 0); drain();
    chk("A_stripe_cnt", scnt_o, 2);
    chk("A_done_pulses", done_seen, 2);
    chk("A_writes", got.size(), 8);
    chk("A_part", part, 0);
    chk("A_cfg", cfg, 0);

    // Back-pressure held for 10 cycles
    ers(); start_run(8'd4);
    accepts = 0;
    repeat (10) begin
      int s0;
      s0 = sent.size();
      drive(1'b1, 1'b1, 0);
      accepts += sent.size() - s0;
    end
    chk("B_accepts", accepts, 4);
    chk("B_rdy_low", rdy, 0);
    drain();
    chk("B_writes", got.size(), 4);

    // Illegal MReg
    ers(); start_run(8'd1); step();
    chk("C_cfg", cfg, 1);
    chk("C_rdy", rdy, 0);
    wr_en = 1'b0; step();

    // Partial stripe
    ers(); start_run(8'd4);
    send_n(6, 0); drain();
    chk("D_part", part, 1);
    chk("D_stripe_cnt", scnt_o, 1);
    chk("D_writes", got.size(), 6);

    // Soft reset with words buffered
    ers(); start_run(8'd4);
    repeat (3) drive(1'b1, 1'b1, 0);
    val = 1'b0; wr_en = 1'b0;
    eng_rstn = 1'b0; step(); eng_rstn = 1'b1; full = 1'b0;
    chk("E_rdy", rdy, 0);
    chk("E_wr_rq", wr_rq, 0);
    chk("E_scnt", scnt_o, 0);
    step();

    // Asynchronous reset mid-write
    ers(); start_run(8'd4);
    repeat (2) drive(1'b1, 1'b1, 0);
    val = 1'b0; full = 1'b0;
    #1 chk("F_writing", wr_rq, 1);
    rstn = 1'b0;
    #1;
    chk("F_async_wr_rq", wr_rq, 0);
    chk("F_async_rdy", rdy, 0);
    chk("F_async_data", wdata, 0);
    model_clear();
    wr_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Random traffic, 1000 words
    ers(); start_run(OUT_W'($urandom_range(2, 8)));
    data = OUT_W'($urandom);
    send_n(1000, 1); drain();
    chk("G_writes", got.size(), 1000);
    mism = 0;
    for (int i = 0; i < 1000 && i < got.size(); i++)
      if (got[i] !== sent[i]) mism++;
    chk("G_order", mism, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
